// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling default and frame-length limits.
// Used by both the transmitter and the receiver so the two ends agree on framing.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;
    localparam logic [3:0]  FRAME_LEN_MIN      = 4'd5;
    localparam logic [3:0]  FRAME_LEN_MAX      = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    function automatic logic [3:0] clamp_frame_length(input logic [3:0] len);
        if (len < FRAME_LEN_MIN) begin
            return FRAME_LEN_MIN;
        end
        if (len > FRAME_LEN_MAX) begin
            return FRAME_LEN_MAX;
        end
        return len;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample counter: bit_end marks the last clock of a bit period.
// It restarts by itself at each bit boundary and is held at zero while clear is high.
module uart_bit_timer import uart_pkg::*; #(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_end = (count == CW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter on the 16x-baud clock: start bit, N data bits LSB first,
// optional parity, one or two stop bits. Frame configuration is captured at acceptance.
module uart_transmitter import uart_pkg::*; #(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk_16bd,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [8:0] tx_data,
    input  logic       parity,
    input  logic       parity_type,
    input  logic       stop_bits,
    input  logic [3:0] frame_length,
    output logic       Tx,
    output logic       tx_ready,
    output logic       tx_done
);

    uart_state_t state;
    logic [8:0]  shift_reg;
    logic [8:0]  masked_data;
    logic [3:0]  bit_idx;
    logic [3:0]  n_bits;
    logic [3:0]  n_in;
    logic        par_en;
    logic        par_bit;
    logic        two_stop;
    logic        stop_cnt;
    logic        bit_end;
    logic        timer_clear;

    // Bits at or above the clamped length are zeroed so they neither shift out nor affect parity.
    always_comb begin
        n_in        = clamp_frame_length(frame_length);
        masked_data = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            masked_data[i] = tx_data[i] && (i < 32'(n_in));
        end
        timer_clear = (state == IDLE);
    end

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk    (clk_16bd),
        .rst    (rst),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            state     <= IDLE;
            Tx        <= 1'b1;
            tx_ready  <= 1'b1;
            tx_done   <= 1'b0;
            shift_reg <= '0;
            bit_idx   <= '0;
            n_bits    <= '0;
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
            two_stop  <= 1'b0;
            stop_cnt  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    Tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        shift_reg <= masked_data;
                        n_bits    <= n_in;
                        par_en    <= parity;
                        par_bit   <= (^masked_data) ^ parity_type;
                        two_stop  <= stop_bits;
                        bit_idx   <= '0;
                        stop_cnt  <= 1'b0;
                        Tx        <= 1'b0;
                        tx_ready  <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        Tx    <= shift_reg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == n_bits - 4'd1) begin
                            if (par_en) begin
                                Tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                Tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            Tx        <= shift_reg[1];
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= bit_idx + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        Tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (two_stop && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            tx_ready <= 1'b1;
                            tx_done  <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    Tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus queues the expected line sequence
// of each frame, a monitor checks Tx/tx_ready/tx_done cycle by cycle once a frame starts.
module tb_uart_transmitter;

    logic       clk_16bd = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [8:0] tx_data = '0;
    logic       parity = 1'b0;
    logic       parity_type = 1'b0;
    logic       stop_bits = 1'b0;
    logic [3:0] frame_length = 4'd8;
    logic       Tx;
    logic       tx_ready;
    logic       tx_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [11:0] seq;    // line bits in send order, first bit at index k-1
        int          k;      // number of bit periods
        int          abort;  // cycles before a reset aborts the frame, 0 = complete frame
        bit          b2b;    // must start exactly one cycle after the previous frame ended
    } exp_t;

    exp_t exp_q[$];

    uart_transmitter #(.OVERSAMPLE(16)) dut (
        .clk_16bd    (clk_16bd),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .parity      (parity),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .frame_length(frame_length),
        .Tx          (Tx),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done)
    );

    always #5 clk_16bd = ~clk_16bd;
    always @(posedge clk_16bd) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [11:0] seq, input int k, input int abort, input bit b2b);
        exp_t e;
        e.seq   = seq;
        e.k     = k;
        e.abort = abort;
        e.b2b   = b2b;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input logic lvl, input int budget, input string name);
        int n = 0;
        while (tx_ready !== lvl && n < budget) begin
            @(negedge clk_16bd);
            n++;
        end
        check(name, tx_ready, lvl);
    endtask

    task automatic send(input logic [8:0] d, input logic p, input logic pt,
                        input logic sb, input logic [3:0] fl);
        @(negedge clk_16bd);
        wait_ready(1'b1, 400, "ready_before_send");
        tx_data      = d;
        parity       = p;
        parity_type  = pt;
        stop_bits    = sb;
        frame_length = fl;
        tx_valid     = 1'b1;
        @(negedge clk_16bd);
        tx_valid = 1'b0;
        repeat (20) @(negedge clk_16bd);
        // Configuration scrambled mid-frame; the frame in flight must not change.
        tx_data      = ~d;
        parity       = ~p;
        parity_type  = ~pt;
        stop_bits    = ~sb;
        frame_length = 4'd2;
        wait_ready(1'b1, 400, "frame_completes");
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        bit   prev_ready = 1'b1;
        bit   chk_done_low = 1'b0;
        int   end_cyc = 0;
        int   frame_no = 0;
        int   limit;
        int   bad;
        logic req_bit;
        while (rst !== 1'b0) @(negedge clk_16bd);
        forever begin
            @(negedge clk_16bd);
            if (chk_done_low) begin
                check("done_pulse_one_cycle", tx_done, 1'b0);
                chk_done_low = 1'b0;
            end
            if (prev_ready && tx_ready === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_start", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    frame_no++;
                    if (e.b2b) check($sformatf("frame%0d_b2b_gap", frame_no), cyc - end_cyc, 1);
                    limit = (e.abort > 0) ? e.abort : 16 * e.k;
                    bad = 0;
                    for (int c = 0; c < limit; c++) begin
                        if (c > 0) @(negedge clk_16bd);
                        req_bit = e.seq[e.k - 1 - c / 16];
                        if (Tx !== req_bit || tx_ready !== 1'b0 || tx_done !== 1'b0) bad++;
                        if (c % 16 == 15 || c == limit - 1) begin
                            check($sformatf("frame%0d_bit%0d_bad_cycles(Tx=%b req=%b)",
                                            frame_no, c / 16, Tx, req_bit), bad, 0);
                            bad = 0;
                        end
                    end
                    @(negedge clk_16bd);
                    if (e.abort > 0) begin
                        check($sformatf("frame%0d_reset_abort_Tx_ready_done", frame_no),
                              {Tx, tx_ready, tx_done}, 3'b110);
                    end else begin
                        check($sformatf("frame%0d_end_Tx_ready_done", frame_no),
                              {Tx, tx_ready, tx_done}, 3'b111);
                        end_cyc      = cyc;
                        chk_done_low = 1'b1;
                    end
                end
            end
            prev_ready = (tx_ready === 1'b1);
        end
    end

    // Stimulus
    initial begin
        repeat (3) @(posedge clk_16bd);
        @(negedge clk_16bd);
        check("reset_Tx", Tx, 1'b1);
        check("reset_ready", tx_ready, 1'b1);
        check("reset_done", tx_done, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk_16bd);

        // 8E1 0x0A5
        expect_frame(12'b0_10100101_0_1, 11, 0, 1'b0);
        send(9'h0A5, 1'b1, 1'b0, 1'b0, 4'd8);
        // 7O2 0x041
        expect_frame(12'b0_1000001_1_11, 11, 0, 1'b0);
        send(9'h041, 1'b1, 1'b1, 1'b1, 4'd7);
        // 9N1 0x1FF
        expect_frame(12'b0_111111111_1, 11, 0, 1'b0);
        send(9'h1FF, 1'b0, 1'b0, 1'b0, 4'd9);
        // frame_length 3 clamps to 5
        expect_frame(12'b0_11111_1, 7, 0, 1'b0);
        send(9'h0FF, 1'b0, 1'b0, 1'b0, 4'd3);
        // frame_length 12 clamps to 9
        expect_frame(12'b0_101010101_1, 11, 0, 1'b0);
        send(9'h155, 1'b0, 1'b0, 1'b0, 4'd12);

        // Back-to-back with tx_valid held high, then a stray mid-frame pulse
        expect_frame(12'b0_10101010_1, 10, 0, 1'b0);
        expect_frame(12'b0_01010101_1, 10, 0, 1'b1);
        @(negedge clk_16bd);
        tx_data      = 9'h055;
        parity       = 1'b0;
        parity_type  = 1'b0;
        stop_bits    = 1'b0;
        frame_length = 4'd8;
        tx_valid     = 1'b1;
        wait_ready(1'b0, 10, "b2b_first_accept");
        tx_data = 9'h0AA;
        wait_ready(1'b1, 400, "b2b_first_done");
        wait_ready(1'b0, 10, "b2b_second_accept");
        tx_valid = 1'b0;
        repeat (60) @(negedge clk_16bd);
        tx_data  = 9'h0F0;
        tx_valid = 1'b1;
        @(negedge clk_16bd);
        tx_valid = 1'b0;
        wait_ready(1'b1, 400, "b2b_second_done");

        // Reset 40 cycles into an 8N1 frame of 0x0F3
        expect_frame(12'b0_11001111_1, 10, 40, 1'b0);
        @(negedge clk_16bd);
        tx_data  = 9'h0F3;
        tx_valid = 1'b1;
        @(posedge clk_16bd);
        #1 tx_valid = 1'b0;
        repeat (39) @(posedge clk_16bd);
        #1 rst = 1'b1;
        @(posedge clk_16bd);
        #1 rst = 1'b0;

        // Normal frame after the abort
        expect_frame(12'b0_10100101_1, 10, 0, 1'b0);
        send(9'h0A5, 1'b0, 1'b0, 1'b0, 4'd8);

        repeat (20) @(negedge clk_16bd);
        check("all_frames_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial transmit side of the UART link; counterpart of the team's UART frame receiver.
- Runs on the 16x-baud clock and accepts one data word per frame through a valid/ready handshake.
- Serialises the frame as: start bit, data bits LSB first, optional parity bit, then one or two stop bits.
- Frame configuration ports are shared with the receiver, so both ends are set up identically.

Parameters:
- OVERSAMPLE, 16, clk_16bd cycles per bit period.

Ports:
- clk_16bd  in  1  16x-baud clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  request to send tx_data.
- tx_data  in  9  data word; bits at index frame_length and above are ignored.
- parity  in  1  1 = parity bit enabled.
- parity_type  in  1  0 = even, 1 = odd.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- frame_length  in  4  number of data bits.
- Tx  out  1  serial line; idles high.
- tx_ready  out  1  high when a new word can be accepted.
- tx_done  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset: synchronous, active-high, on the clk_16bd edge. After the reset edge: Tx=1, tx_ready=1, tx_done=0, state=IDLE, all counters and shift register cleared.
- Reset mid-frame aborts the frame with the same values. No partial bit is stretched.
- All outputs are registered.
- Acceptance: tx_valid && tx_ready at a rising edge.
  - The same edge latches tx_data, parity, parity_type, stop_bits and the clamped frame_length.
  - Config changes during a frame have no effect.
  - tx_valid while tx_ready=0 is ignored; there is no queueing.
- frame_length clamp: 0..4 -> 5; 10..15 -> 9; 5..9 used as-is. Call the result N.
- States:
  - IDLE: Tx=1, tx_ready=1. On acceptance -> START, with Tx=0 and tx_ready=0 after that edge.
  - START: Tx=0 for OVERSAMPLE cycles -> DATA.
  - DATA: Tx=data[i], i = 0..N-1, each held OVERSAMPLE cycles. After bit N-1 -> PARITY if parity=1, else STOP.
  - PARITY: Tx = XOR(data[N-1:0]) ^ parity_type, held OVERSAMPLE cycles -> STOP. Even parity makes the total count of ones even.
  - STOP: Tx=1 for OVERSAMPLE cycles, or 2*OVERSAMPLE cycles when stop_bits=1 (1-bit stop counter). Then -> IDLE.
- Bit timer: a 4-bit sample counter, cleared on each state entry. Bit end is when the counter reaches OVERSAMPLE-1.
- Frame end (edge that leaves STOP): state=IDLE, tx_ready=1, tx_done=1 for exactly one cycle.
- Frame duration: tx_ready is low for exactly 16*K cycles, where K = 1 + N + parity + (stop_bits ? 2 : 1).
- Back-to-back frames: if tx_valid is high in the cycle tx_ready returns, the next word is accepted on the following edge. Tx goes low one cycle after the stop bit ends, giving a minimum idle of one clk_16bd cycle between frames.
- Width rules:
  - Data index: 4 bits.
  - Shift register: 9 bits, shifted right; Tx takes bit 0.

Decomposition:
- Shared package uart_pkg: state encodings (IDLE, START, DATA, PARITY, STOP), OVERSAMPLE default, FRAME_LEN_MIN=5, FRAME_LEN_MAX=9. The receiver reuses these.
- One sub-module: uart_bit_timer.
  - Counter with clear input.
  - Outputs bit_end when the count reaches OVERSAMPLE-1.
  - The transmitter instantiates it; the receiver can adopt it later.

Test Plan:
- 8E1, tx_data=0x0A5 -> Tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 16 cycles. tx_ready low for 176 cycles. tx_done pulses once.
- 7O2, tx_data=0x041 -> data bits 1,0,0,0,0,0,1, parity=1, two stop bits. tx_ready low for 176 cycles.
- 9N1, tx_data=0x1FF -> start, nine 1s, stop. tx_ready low 176 cycles. Loopback through the receiver yields frame=0x1FF, frame_valid.
- frame_length=3, tx_data=0x0FF, 8N1 otherwise -> exactly 5 data bits sent (1,1,1,1,1). tx_ready low 112 cycles.
- tx_valid held high with two words, 0x055 then 0x0AA, 8N1 -> second start bit begins 1 cycle after first stop ends. Second word is accepted only once. Pulsing tx_valid mid-frame is ignored.
- rst asserted 40 cycles into an 8N1 frame -> next edge: Tx=1, tx_ready=1, tx_done=0. A new word is accepted normally afterwards.
